// File: rtl/sm3_pad_blk_rcvr.sv
// Collects padded SM3 message words into 512-bit blocks using two ping-pong slots,
// and presents each complete block downstream through a valid/ready handshake.
module sm3_pad_blk_rcvr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] pad_otpt_d_i,
  input  logic          pad_otpt_vld_i,
  input  logic          pad_otpt_lst_i,
  output logic          pad_otpt_ena_o,
  output logic [511:0]  blk_d_o,
  output logic          blk_vld_o,
  output logic          blk_lst_o,
  input  logic          blk_rdy_i,
  output logic          err_o
);

  localparam int WPB = 512 / DW;
  localparam int WCW = $clog2(WPB);

  // Element WPB-1 is word 0, so the packed slot is already in output bit order.
  typedef logic [WPB-1:0][DW-1:0] slot_t;

  slot_t          slot_d [2];
  logic [1:0]     slot_lst;
  logic [1:0]     occ;
  logic [1:0]     occ_nxt;
  logic [WCW-1:0] wcnt;
  logic           wr_sel;
  logic           rd_sel;
  logic           ena;
  logic           err;

  logic           acc;
  logic           last_word;
  logic           commit;
  logic           early_lst;
  logic           pop;
  slot_t          fill;

  // NOTE: combinational logic uses blocking '=' with every output defaulted first,
  // so no latch is inferred; the state register below uses only '<='.
  always_comb begin
    acc       = ena & pad_otpt_vld_i;
    last_word = (wcnt == WCW'(WPB - 1));
    commit    = acc & (last_word | pad_otpt_lst_i);
    early_lst = acc & pad_otpt_lst_i & ~last_word;
    pop       = (occ != 2'd0) & blk_rdy_i;
    occ_nxt   = occ + {1'b0, commit} - {1'b0, pop};

    // Word 0 of a block starts from a cleared slot, so unwritten words read as 0.
    fill = (wcnt == '0) ? '0 : slot_d[wr_sel];
    fill[WCW'(WPB - 1) - wcnt] = pad_otpt_d_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the block slots are reset as well, because reset must leave blk_d_o
      // at zero and discard any partial or pending block.
      slot_d[0] <= '0;
      slot_d[1] <= '0;
      slot_lst  <= '0;
      occ       <= '0;
      wcnt      <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      ena       <= 1'b0;
      err       <= 1'b0;
    end else begin
      occ <= occ_nxt;
      // ena is registered and tracks occ_nxt, so a free slot always exists while it is high.
      ena <= (occ_nxt < 2'd2);

      if (acc) begin
        slot_d[wr_sel] <= fill;
        wcnt           <= commit ? '0 : wcnt + 1'b1;
      end

      if (commit) begin
        slot_lst[wr_sel] <= pad_otpt_lst_i;
        wr_sel           <= ~wr_sel;
      end

      if (early_lst) err <= 1'b1;
      if (pop)       rd_sel <= ~rd_sel;
    end
  end

  assign pad_otpt_ena_o = ena;
  assign blk_d_o        = slot_d[rd_sel];
  assign blk_vld_o      = (occ != 2'd0);
  assign blk_lst_o      = slot_lst[rd_sel];
  assign err_o          = err;

endmodule
